// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
//   Hardwired control sequencer for the Mini-SRC datapath. It runs the
//   instruction fetch (T0-T2), decodes the opcode held in the IR and steps
//   through the execute T-states for register ALU, unary, MUL/DIV, NOP and
//   HALT instructions, driving every datapath strobe along the way.
//
// Ports
//   clock        system clock, all state changes on the rising edge
//   clear        synchronous reset, active-low
//   IR           instruction register contents (opcode in IR[31:27])
//   mem_ready    memory read data valid this cycle
//   PCout..IRin  fetch-path strobes
//   Yin..LOin    ALU / result register strobes
//   Gra..Rout    register-field selects and register enables
//   opcode       ALU operation code, non-zero only in ALU-op states
//   step         current T-step number (0-6), 0 in RST and HALTED
//   run          processor running (every state except RST and HALTED)
//   illegal      sticky flag, set when an undefined opcode retires
//   instr_count  count of retired instructions, wraps at all-ones
module alu_instr_sequencer #(
  parameter int              OP_W     = 5,
  parameter logic [OP_W-1:0] NOP_OPC  = 5'b11010,
  parameter logic [OP_W-1:0] HALT_OPC = 5'b11011,
  parameter int              CNT_W    = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             IncPC,
  output logic             PCin,
  output logic             MARin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic [OP_W-1:0]  opcode,
  output logic [2:0]       step,
  output logic             run,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  // T1 is split in two: the first T1 cycle loads the PC, while T1_WAIT
  // only keeps the memory read going. This keeps the PC load a single pulse
  // however long memory takes, without a separate "first cycle" flag.
  typedef enum logic [3:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T1_WAIT,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALTED
  } state_t;

  state_t state;

  logic [OP_W-1:0] opc;
  logic            is_rr;
  logic            is_md;
  logic            is_un;
  logic            is_halt;
  logic            is_bad;
  logic            retire;
  logic            ir_unused;

  assign opc       = IR[31 -: OP_W];
  assign ir_unused = ^IR[31-OP_W:0];

  // Instruction class decode; anything outside the known classes is
  // treated as a NOP that also raises the illegal flag.
  always_comb begin
    is_rr   = (opc >= OP_W'(3)) && (opc <= OP_W'(11));
    is_md   = (opc == OP_W'(15)) || (opc == OP_W'(16));
    is_un   = (opc == OP_W'(17)) || (opc == OP_W'(18));
    is_halt = (opc == HALT_OPC);
    is_bad  = !(is_rr || is_md || is_un || is_halt || (opc == NOP_OPC));
  end

  // The last execute state of each class; the count steps on the edge
  // leaving it and the sequencer goes straight back to T0.
  always_comb begin
    retire = ((state == S_T3) && !(is_rr || is_md || is_un)) ||
             ((state == S_T4) && is_un) ||
             ((state == S_T5) && !is_md) ||
             (state == S_T6);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= S_RST;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      case (state)
        S_RST:     state <= S_T0;
        S_T0:      state <= S_T1;
        S_T1,
        S_T1_WAIT: state <= mem_ready ? S_T2 : S_T1_WAIT;
        S_T2:      state <= S_T3;
        S_T3: begin
          if (is_rr || is_md || is_un) begin
            state <= S_T4;
          end else if (is_halt) begin
            state <= S_HALTED;
          end else begin
            state <= S_T0;
            if (is_bad) begin
              illegal <= 1'b1;
            end
          end
        end
        S_T4:      state <= is_un ? S_T0 : S_T5;
        S_T5:      state <= is_md ? S_T6 : S_T0;
        S_T6:      state <= S_T0;
        S_HALTED:  state <= S_HALTED;
        default:   state <= S_RST;
      endcase
    end
  end

  // Moore strobe decode from the state register and the IR opcode.
  always_comb begin
    PCout    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    opcode   = '0;
    step     = 3'd0;
    run      = (state != S_RST) && (state != S_HALTED);
    case (state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        step    = 3'd1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T1_WAIT: begin
        step  = 3'd1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        step   = 3'd2;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        step = 3'd3;
        if (is_rr) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_md) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_un) begin
          Grb    = 1'b1;
          Rout   = 1'b1;
          Zlowin = 1'b1;
          opcode = opc;
        end
      end
      S_T4: begin
        step = 3'd4;
        if (is_rr) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          Zlowin = 1'b1;
          opcode = opc;
        end else if (is_md) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Zlowin  = 1'b1;
          Zhighin = 1'b1;
          opcode  = opc;
        end else if (is_un) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end
      end
      S_T5: begin
        step = 3'd5;
        if (is_md) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end else begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end
      end
      S_T6: begin
        step     = 3'd6;
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer
//   Self-checking bench for alu_instr_sequencer. A reference model expands
//   each instruction into its expected per-cycle list of strobes, opcode and
//   step, and keeps the retired count and illegal flag as plain integers.
//   Directed instructions are followed by a run of random ones.
module tb_alu_instr_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] IR;
  logic        mem_ready;
  logic        PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  opcode;
  logic [2:0]  step;
  logic        run;
  logic        illegal;
  logic [15:0] instr_count;

  alu_instr_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .opcode(opcode), .step(step), .run(run), .illegal(illegal),
    .instr_count(instr_count)
  );

  localparam logic [19:0] M_PCOUT    = 20'h80000;
  localparam logic [19:0] M_INCPC    = 20'h40000;
  localparam logic [19:0] M_PCIN     = 20'h20000;
  localparam logic [19:0] M_MARIN    = 20'h10000;
  localparam logic [19:0] M_READ     = 20'h08000;
  localparam logic [19:0] M_MDRIN    = 20'h04000;
  localparam logic [19:0] M_MDROUT   = 20'h02000;
  localparam logic [19:0] M_IRIN     = 20'h01000;
  localparam logic [19:0] M_YIN      = 20'h00800;
  localparam logic [19:0] M_ZLOWIN   = 20'h00400;
  localparam logic [19:0] M_ZHIGHIN  = 20'h00200;
  localparam logic [19:0] M_ZLOWOUT  = 20'h00100;
  localparam logic [19:0] M_ZHIGHOUT = 20'h00080;
  localparam logic [19:0] M_HIIN     = 20'h00040;
  localparam logic [19:0] M_LOIN     = 20'h00020;
  localparam logic [19:0] M_GRA      = 20'h00010;
  localparam logic [19:0] M_GRB      = 20'h00008;
  localparam logic [19:0] M_GRC      = 20'h00004;
  localparam logic [19:0] M_RIN      = 20'h00002;
  localparam logic [19:0] M_ROUT     = 20'h00001;

  typedef struct {
    logic [19:0] strb;
    logic [4:0]  opc;
    logic [2:0]  stp;
  } cyc_t;

  cyc_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   model_count = 0;
  bit   model_ill   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] obs_strobes();
    return {PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin,
            Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
            Gra, Grb, Grc, Rin, Rout};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [19:0] s, input logic [4:0] o, input logic [2:0] t);
    cyc_t c;
    c.strb = s;
    c.opc  = o;
    c.stp  = t;
    exp_q.push_back(c);
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    return (op >= 5'd3 && op <= 5'd11) || op == 5'd15 || op == 5'd16 ||
           op == 5'd17 || op == 5'd18 || op == 5'd26 || op == 5'd27;
  endfunction

  // Expected cycle list for one instruction, fetch included.
  task automatic model_instr(input logic [31:0] ir, input int waits);
    logic [4:0] op;
    op = ir[31:27];
    exp_q.delete();
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 5'd0, 3'd0);
    push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 3'd1);
    for (int w = 0; w < waits; w++) push(M_READ | M_MDRIN, 5'd0, 3'd1);
    push(M_MDROUT | M_IRIN, 5'd0, 3'd2);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0, 3'd3);
      push(M_GRC | M_ROUT | M_ZLOWIN, op, 3'd4);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 3'd5);
    end else if (op == 5'd15 || op == 5'd16) begin
      push(M_GRA | M_ROUT | M_YIN, 5'd0, 3'd3);
      push(M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN, op, 3'd4);
      push(M_ZLOWOUT | M_LOIN, 5'd0, 3'd5);
      push(M_ZHIGHOUT | M_HIIN, 5'd0, 3'd6);
    end else if (op == 5'd17 || op == 5'd18) begin
      push(M_GRB | M_ROUT | M_ZLOWIN, op, 3'd3);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 3'd4);
    end else begin
      push(20'h0, 5'd0, 3'd3);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " strobes"}, {12'h0, obs_strobes()}, 32'h0);
    check({tag, " opcode"}, {27'h0, opcode}, 32'h0);
    check({tag, " step"}, {29'h0, step}, 32'h0);
    check({tag, " run"}, {31'h0, run}, 32'h0);
    check({tag, " count"}, {16'h0, instr_count}, model_count);
    check({tag, " illegal"}, {31'h0, illegal}, {31'h0, model_ill});
  endtask

  // Runs one instruction starting in T0 and checks every cycle. A
  // non-negative abort_at pulls clear low after checking that cycle.
  task automatic run_instr(input logic [31:0] ir, input int waits, input int abort_at);
    cyc_t  c;
    string tg;
    model_instr(ir, waits);
    IR = ir;
    for (int k = 0; k < exp_q.size(); k++) begin
      c  = exp_q[k];
      tg = $sformatf("ir=%08h k=%0d", ir, k);
      check({tg, " strobes"}, {12'h0, obs_strobes()}, {12'h0, c.strb});
      check({tg, " opcode"}, {27'h0, opcode}, {27'h0, c.opc});
      check({tg, " step"}, {29'h0, step}, {29'h0, c.stp});
      check({tg, " run"}, {31'h0, run}, 32'h1);
      if (k == abort_at) begin
        clear = 1'b0;
        @(posedge clock); #1;
        model_count = 0;
        model_ill   = 0;
        return;
      end
      mem_ready = (k >= 1 && k <= waits) ? 1'b0 : 1'b1;
      @(posedge clock); #1;
    end
    model_count = (model_count + 1) % 65536;
    if (!is_legal(ir[31:27])) model_ill = 1;
    tg = $sformatf("ir=%08h retire", ir);
    check({tg, " count"}, {16'h0, instr_count}, model_count);
    check({tg, " illegal"}, {31'h0, illegal}, {31'h0, model_ill});
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] rir;
    clear     = 1'b0;
    mem_ready = 1'b1;
    IR        = 32'h0;

    // reset held for two edges, then released
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_idle("reset");
    clear = 1'b1;
    check_idle("release");
    @(posedge clock); #1;

    run_instr(32'h50918000, 0, -1);   // ror R1,R2,R3
    run_instr(32'h79A00000, 0, -1);   // mul R3,R4
    run_instr(32'h50918000, 3, -1);   // ror with a 3-cycle memory wait
    run_instr(32'h8A000000, 1, -1);   // neg
    run_instr(32'hF8000000, 0, -1);   // undefined opcode
    run_instr(32'hD0000000, 0, -1);   // nop, illegal stays set

    for (int i = 0; i < 30; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      rir = {op, 27'($urandom)};
      run_instr(rir, int'($urandom_range(0, 3)), -1);
    end

    run_instr(32'hD8000000, 0, -1);   // halt
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom);
      check_idle($sformatf("halted %0d", i));
      @(posedge clock); #1;
    end
    clear = 1'b0;
    @(posedge clock); #1;
    model_count = 0;
    model_ill   = 0;
    check_idle("halt reset");
    clear     = 1'b1;
    mem_ready = 1'b1;
    @(posedge clock); #1;

    run_instr(32'h50918000, 0, -1);
    run_instr(32'h50918000, 0, 4);    // reset during T4
    check_idle("abort");
    clear = 1'b1;
    @(posedge clock); #1;
    run_instr(32'h90000000, 2, -1);   // not, after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
